motor_cmd_decoder: RTL and testbench

- Sits between the SPI slave (SSP) and the bank of step-generator channels (motorCtrlSimple instances).
- Consumes 16-bit words from SSP and decodes a two-word command: a header word followed by a data word.
- Commits divider, direction and enable to the addressed motor atomically, and pulses that motor's position reset when requested.
- Selects the next 16-bit reply word for SSP: the addressed motor's position or a command acknowledge.

---
 rtl/motor_cmd_pkg.sv | 31 +++
 rtl/motor_cmd_decoder_bank.sv | 59 +++++
 rtl/motor_cmd_decoder.sv | 177 +++++++++++++++++
 tb/tb_motor_cmd_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg
//   Shared definitions for the motor command decoder: bit positions of the
//   header/data word fields, the decoder state encoding and the fixed reply
//   words returned to the SPI slave.
package motor_cmd_pkg;

  // Word type: 0 = header, 1 = data.
  localparam int TYPE_BIT = 15;

  // Header word fields.
  localparam int IDX_LSB  = 0;
  localparam int IDX_MSB  = 3;
  localparam int IDX_W    = IDX_MSB - IDX_LSB + 1;
  localparam int DIR_BIT  = 4;
  localparam int RST_BIT  = 5;

  // Data word fields.
  localparam int ENA_BIT  = 13;
  localparam int DIV_MSB  = 12;

  // Reply words.
  localparam logic [15:0] ACK_BASE      = 16'h8000;
  localparam logic [15:0] REPLY_BAD_IDX = 16'hFFFF;
  localparam logic [15:0] REPLY_TIMEOUT = 16'hFFFE;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/motor_cmd_decoder_bank.sv
// motor_reg_bank
//   Per-motor divider / direction / enable registers plus a one-cycle
//   position-reset pulse. All writes go through a single commit strobe that
//   carries the target motor index, so a motor's settings change atomically.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   commit            write strobe for the motor selected by idx
//   idx               target motor index
//   div_in            new divider value
//   dir_in, ena_in    new direction / step enable
//   rst_req           pulse pos_reset[idx] on this commit
//   divider           flattened dividers, motor m at [m*DIV_W +: DIV_W]
//   move_dir          per-motor direction
//   step_clock_ena    per-motor step enable
//   pos_reset         per-motor one-cycle position-reset pulse
module motor_reg_bank
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS = 10,
  parameter int DIV_W      = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        commit,
  input  logic [IDX_W-1:0]            idx,
  input  logic [DIV_W-1:0]            div_in,
  input  logic                        dir_in,
  input  logic                        ena_in,
  input  logic                        rst_req,
  output logic [NUM_MOTORS*DIV_W-1:0] divider,
  output logic [NUM_MOTORS-1:0]       move_dir,
  output logic [NUM_MOTORS-1:0]       step_clock_ena,
  output logic [NUM_MOTORS-1:0]       pos_reset
);

  // NOTE: this bank drives live motor channels, so every register is reset
  // to a known stopped state rather than left to power up random.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider        <= '0;
      move_dir       <= '0;
      step_clock_ena <= '0;
      pos_reset      <= '0;
    end else begin
      // pos_reset is a strobe: cleared every cycle unless this commit sets it.
      pos_reset <= '0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
        if (commit && idx == IDX_W'(m)) begin
          divider[m*DIV_W +: DIV_W] <= div_in;
          move_dir[m]               <= dir_in;
          step_clock_ena[m]         <= ena_in;
          pos_reset[m]              <= rst_req;
        end
      end
    end
  end

endmodule

// File: rtl/motor_cmd_decoder.sv
// motor_cmd_decoder
//   Decodes two-word commands (header, then data) arriving from the SPI
//   slave and commits divider/direction/enable to the addressed motor.
//   Also selects the reply word for the next SPI transfer: the addressed
//   motor's position (top 16 bits) after a header, an acknowledge after a
//   data word, or a fixed error code.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   word_received   SSP level flag, high while recvd_data holds a new word
//   recvd_data      received 16-bit word
//   cur_position    flattened positions, motor m at [m*POS_W +: POS_W]
//   err_clr         clears cmd_error (a same-cycle error wins)
//   divider, move_dir, step_clock_ena, pos_reset   per-motor controls
//   word_to_send    reply word for the next transfer
//   cmd_error       sticky protocol error flag
//   busy            high while waiting for the data word
module motor_cmd_decoder
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS  = 10,
  parameter int DIV_W       = 13,
  parameter int POS_W       = 20,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        word_received,
  input  logic [15:0]                 recvd_data,
  input  logic [NUM_MOTORS*POS_W-1:0] cur_position,
  input  logic                        err_clr,
  output logic [NUM_MOTORS*DIV_W-1:0] divider,
  output logic [NUM_MOTORS-1:0]       move_dir,
  output logic [NUM_MOTORS-1:0]       step_clock_ena,
  output logic [NUM_MOTORS-1:0]       pos_reset,
  output logic [15:0]                 word_to_send,
  output logic                        cmd_error,
  output logic                        busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic               wr_q;
  logic               accept;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dir_q, dir_d;
  logic               rst_req_q, rst_req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        reply_q, reply_d;
  logic               err_q, err_set;
  logic               commit;

  // Field decode of the incoming word.
  logic               is_data;
  logic [IDX_W-1:0]   hdr_idx;
  logic               hdr_valid;
  logic               data_ena;
  logic [DIV_W-1:0]   data_div;
  logic [15:0]        pos_win;

  // Bits that are intentionally ignored (reserved word bits, position LSBs).
  logic               unused_ok;
  assign unused_ok = &{1'b0, recvd_data, cur_position};

  // A word is accepted only on the rising edge of the SSP level flag, so a
  // long high period still yields a single accept.
  assign accept    = word_received & ~wr_q;

  assign is_data   = recvd_data[TYPE_BIT];
  assign hdr_idx   = recvd_data[IDX_MSB:IDX_LSB];
  assign hdr_valid = 32'(hdr_idx) < NUM_MOTORS;
  assign data_ena  = recvd_data[ENA_BIT];
  assign data_div  = DIV_W'(recvd_data[DIV_MSB:0]);

  // Top 16 bits of the position for the motor named in the header.
  always_comb begin
    pos_win = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (hdr_idx == IDX_W'(m)) pos_win = cur_position[m*POS_W + (POS_W-16) +: 16];
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    rst_req_d = rst_req_q;
    cnt_d     = (state_q == WAIT_DATA) ? cnt_q + CNT_W'(1) : cnt_q;
    reply_d   = reply_q;
    err_set   = 1'b0;
    commit    = 1'b0;

    if (accept) begin
      if (is_data) begin
        if (state_q == WAIT_DATA) begin
          commit  = 1'b1;
          reply_d = ACK_BASE | {10'd0, data_ena, dir_q, idx_q};
          state_d = IDLE;
        end else begin
          err_set = 1'b1;
        end
      end else begin
        // A header while waiting abandons the pending command, then is
        // handled exactly like a header in IDLE.
        if (state_q == WAIT_DATA) err_set = 1'b1;
        if (hdr_valid) begin
          idx_d     = hdr_idx;
          dir_d     = recvd_data[DIR_BIT];
          rst_req_d = recvd_data[RST_BIT];
          cnt_d     = '0;
          state_d   = WAIT_DATA;
          reply_d   = pos_win;
        end else begin
          err_set = 1'b1;
          state_d = IDLE;
          reply_d = REPLY_BAD_IDX;
        end
      end
    end else if (state_q == WAIT_DATA && cnt_q == CNT_LAST) begin
      err_set = 1'b1;
      state_d = IDLE;
      reply_d = REPLY_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      dir_q     <= 1'b0;
      rst_req_q <= 1'b0;
      cnt_q     <= '0;
      reply_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= word_received;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      rst_req_q <= rst_req_d;
      cnt_q     <= cnt_d;
      reply_q   <= reply_d;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  motor_reg_bank #(
    .NUM_MOTORS (NUM_MOTORS),
    .DIV_W      (DIV_W)
  ) u_bank (
    .clk            (clk),
    .reset          (reset),
    .commit         (commit),
    .idx            (idx_q),
    .div_in         (data_div),
    .dir_in         (dir_q),
    .ena_in         (data_ena),
    .rst_req        (rst_req_q),
    .divider        (divider),
    .move_dir       (move_dir),
    .step_clock_ena (step_clock_ena),
    .pos_reset      (pos_reset)
  );

  assign word_to_send = reply_q;
  assign cmd_error    = err_q;
  assign busy         = (state_q == WAIT_DATA);

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// tb_motor_cmd_decoder
//   Directed stimulus with hand-computed expectations queued per command;
//   a monitor pops one expectation each time the decoder responds (one cycle
//   after an accepted word, or when busy drops on timeout).
module tb_motor_cmd_decoder;

  localparam int NM = 10;
  localparam int DW = 13;
  localparam int PW = 20;
  localparam int TO = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              word_received = 1'b0;
  logic [15:0]       recvd_data = '0;
  logic [NM*PW-1:0]  cur_position = '0;
  logic              err_clr = 1'b0;
  logic [NM*DW-1:0]  divider;
  logic [NM-1:0]     move_dir;
  logic [NM-1:0]     step_clock_ena;
  logic [NM-1:0]     pos_reset;
  logic [15:0]       word_to_send;
  logic              cmd_error;
  logic              busy;

  motor_cmd_decoder #(
    .NUM_MOTORS (NM),
    .DIV_W      (DW),
    .POS_W      (PW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .word_received  (word_received),
    .recvd_data     (recvd_data),
    .cur_position   (cur_position),
    .err_clr        (err_clr),
    .divider        (divider),
    .move_dir       (move_dir),
    .step_clock_ena (step_clock_ena),
    .pos_reset      (pos_reset),
    .word_to_send   (word_to_send),
    .cmd_error      (cmd_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      reply;
    logic             busy;
    logic             err;
    logic [NM*DW-1:0] div;
    logic [NM-1:0]    dir;
    logic [NM-1:0]    ena;
    logic [NM-1:0]    pr;
    int               delay;   // cycles after previous accept, -1 = don't care
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  // Hand-maintained motor register model.
  logic [DW-1:0] m_div [NM];
  logic          m_dir [NM];
  logic          m_ena [NM];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_motor(input int m, input logic [DW-1:0] d, input logic dr, input logic en);
    m_div[m] = d;
    m_dir[m] = dr;
    m_ena[m] = en;
  endtask

  task automatic push_exp(input logic [15:0] reply, input logic bsy, input logic err,
                          input logic [NM-1:0] pr, input int delay);
    exp_t e;
    e.reply = reply;
    e.busy  = bsy;
    e.err   = err;
    e.pr    = pr;
    e.delay = delay;
    for (int m = 0; m < NM; m++) begin
      e.div[m*DW +: DW] = m_div[m];
      e.dir[m]          = m_dir[m];
      e.ena[m]          = m_ena[m];
    end
    exp_q.push_back(e);
  endtask

  // Hold word_received high for three cycles; err_clr only on the accept edge.
  task automatic send_word(input logic [15:0] w, input logic clr);
    @(negedge clk);
    recvd_data    = w;
    word_received = 1'b1;
    err_clr       = clr;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    word_received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Bench-side accept detector (from the stimulus, not from the DUT).
  logic tb_wr_q = 1'b0;
  logic tb_acc  = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      tb_acc  = 1'b0;
      tb_wr_q = 1'b0;
    end else begin
      tb_acc  = word_received && !tb_wr_q;
      tb_wr_q = word_received;
    end
  end

  // Monitor / scoreboard.
  logic busy_prev = 1'b0;
  logic chk_zero  = 1'b0;
  int   acc_cyc   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_prev = 1'b0;
      chk_zero  = 1'b0;
    end else begin
      if (chk_zero) begin
        check("pos_reset_pulse_end", 256'(pos_reset), 256'(0));
        chk_zero = 1'b0;
      end
      if (tb_acc || (busy_prev && !busy)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_response: reply %0h with no queued expectation", word_to_send);
        end else begin
          e = exp_q.pop_front();
          check("word_to_send",   256'(word_to_send),   256'(e.reply));
          check("busy",           256'(busy),           256'(e.busy));
          check("cmd_error",      256'(cmd_error),      256'(e.err));
          check("divider",        256'(divider),        256'(e.div));
          check("move_dir",       256'(move_dir),       256'(e.dir));
          check("step_clock_ena", 256'(step_clock_ena), 256'(e.ena));
          check("pos_reset",      256'(pos_reset),      256'(e.pr));
          if (e.delay >= 0) check("timeout_cycles", 256'(cyc - acc_cyc), 256'(e.delay));
          chk_zero = 1'b1;
        end
        if (tb_acc) acc_cyc = cyc;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < NM; m++) set_motor(m, '0, 1'b0, 1'b0);
    cur_position[0*PW +: PW] = 20'hFEDCB;
    cur_position[1*PW +: PW] = 20'h12345;
    cur_position[2*PW +: PW] = 20'h0F0F0;
    cur_position[3*PW +: PW] = 20'h55555;
    cur_position[5*PW +: PW] = 20'hABCDE;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_word_to_send", 256'(word_to_send), 256'(0));
    check("reset_outputs", 256'({busy, cmd_error, pos_reset, step_clock_ena, move_dir}), 256'(0));
    check("reset_divider", 256'(divider), 256'(0));

    // Motor 3, dir 0, pos reset; then divider 200 with enable.
    push_exp(16'h5555, 1'b1, 1'b0, '0, -1);
    send_word(16'h0023, 1'b0);
    set_motor(3, 13'd200, 1'b0, 1'b1);
    push_exp(16'h8023, 1'b0, 1'b0, NM'(1) << 3, -1);
    send_word(16'hA0C8, 1'b0);

    // Motor 5 position readback, then commit dir 1 / disabled.
    push_exp(16'hABCD, 1'b1, 1'b0, '0, -1);
    send_word(16'h0015, 1'b0);
    set_motor(5, 13'd0, 1'b1, 1'b0);
    push_exp(16'h8015, 1'b0, 1'b0, '0, -1);
    send_word(16'h8000, 1'b0);

    // Bad index; then data in IDLE with err_clr on the same edge (set wins).
    push_exp(16'hFFFF, 1'b0, 1'b1, '0, -1);
    send_word(16'h000C, 1'b0);
    push_exp(16'hFFFF, 1'b0, 1'b1, '0, -1);
    send_word(16'h9FFF, 1'b1);
    pulse_clr();
    @(negedge clk);
    check("err_clr_1", 256'(cmd_error), 256'(0));

    // Header motor 1 superseded by header motor 2, then data.
    push_exp(16'h1234, 1'b1, 1'b0, '0, -1);
    send_word(16'h0001, 1'b0);
    push_exp(16'h0F0F, 1'b1, 1'b1, '0, -1);
    send_word(16'h0012, 1'b0);
    set_motor(2, 13'd100, 1'b1, 1'b0);
    push_exp(16'h8012, 1'b0, 1'b1, '0, -1);
    send_word(16'h8064, 1'b0);
    pulse_clr();

    // Highest index with ignored header bits set, max divider, ignored bit 14.
    push_exp(16'h0000, 1'b1, 1'b0, '0, -1);
    send_word(16'h7FE9, 1'b0);
    set_motor(9, 13'h1FFF, 1'b0, 1'b0);
    push_exp(16'h8009, 1'b0, 1'b0, NM'(1) << 9, -1);
    send_word(16'hDFFF, 1'b0);

    // Timeout: header motor 0, no data word.
    push_exp(16'hFEDC, 1'b1, 1'b0, '0, -1);
    push_exp(16'hFFFE, 1'b0, 1'b1, '0, TO);
    send_word(16'h0000, 1'b0);
    repeat (TO + 5) @(negedge clk);
    pulse_clr();
    @(negedge clk);
    check("err_clr_2", 256'(cmd_error), 256'(0));

    // Asynchronous reset while in WAIT_DATA.
    push_exp(16'h0000, 1'b1, 1'b0, '0, -1);
    send_word(16'h0014, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          256'({word_to_send, busy, cmd_error, pos_reset, step_clock_ena, move_dir}), 256'(0));
    check("async_reset_divider", 256'(divider), 256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int m = 0; m < NM; m++) set_motor(m, '0, 1'b0, 1'b0);

    // Lone data word after reset: error, no commit.
    push_exp(16'h0000, 1'b0, 1'b1, '0, -1);
    send_word(16'hA0C8, 1'b0);

    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
